// File: rtl/pc_unit_pkg.sv
// pc_defs: shared encodings for the program counter stage
package pc_defs;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b01;
    localparam logic [1:0] PC_REG  = 2'b10;
    localparam logic [1:0] PC_RSVD = 2'b11;

    localparam logic [31:0] WORD = 32'd4;

    typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1, S_FAULT = 2'd2} state_t;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: parser controls in, PC and status out
interface pc_unit_if;

    logic        stall;
    logic [1:0]  pc_sel;
    logic        add_sel;
    logic        zero;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] retired;

    modport master (
        output stall, pc_sel, add_sel, zero, imm, addr, reg_target,
        input  pc, pc_plus4, fault, fault_pc, retired
    );

    modport slave (
        input  stall, pc_sel, add_sel, zero, imm, addr, reg_target,
        output pc, pc_plus4, fault, fault_pc, retired
    );

endinterface

// File: rtl/pc_unit_target_gen.sv
// pc_target_gen: next-PC target selection and legality check
module pc_target_gen
    import pc_defs::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic        add_sel,
    input  logic        zero,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    input  logic [31:0] reg_target,
    output logic [31:0] target,
    output logic        illegal
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_plus4;
    logic [31:0] offset;

    // reserved selector falls back to the sequential value; it traps anyway
    always_comb begin
        pc_plus4 = pc + WORD;
        offset   = (add_sel & zero) ? {{14{imm[15]}}, imm, 2'b00} : 32'd0;
        target   = pc_sel == PC_JUMP ? {pc_plus4[31:28], addr, 2'b00} :
                   pc_sel == PC_REG  ? reg_target : pc_plus4 + offset;
        illegal  = (pc_sel == PC_RSVD) | (|target[1:0]) | (target > LAST_PC);
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC register with stall, sticky fault trap and retire counter
module pc_unit
    import pc_defs::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_BYTES   = 1024
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, fault_pc_q, retired_q, target;
    logic        illegal, advance, trap;

    pc_target_gen #(.IMEM_BYTES(IMEM_BYTES)) u_target (
        .pc         (pc_q),
        .pc_sel     (bus.pc_sel),
        .add_sel    (bus.add_sel),
        .zero       (bus.zero),
        .imm        (bus.imm),
        .addr       (bus.addr),
        .reg_target (bus.reg_target),
        .target     (target),
        .illegal    (illegal)
    );

    // stall always wins over a trap; a stall release only returns to RUN
    always_comb begin
        state_d = state_q == S_FAULT ? S_FAULT :
                  bus.stall          ? S_STALL :
                  state_q == S_STALL ? S_RUN :
                  illegal            ? S_FAULT : S_RUN;
        advance = (state_q == S_RUN) & ~bus.stall & ~illegal;
        trap    = (state_q == S_RUN) & ~bus.stall & illegal;
    end

    // state, PC, fault capture and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_VECTOR;
            fault_pc_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                pc_q      <= target;
                retired_q <= retired_q + 32'd1;
            end
            if (trap)
                fault_pc_q <= target;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + WORD;
    assign bus.fault    = state_q == S_FAULT;
    assign bus.fault_pc = fault_pc_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with a queue scoreboard and negedge monitor
module tb_pc_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        logic        flt;
        logic [31:0] fpc;
        logic        cfpc;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_tick = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;
    exp_t sb[$];

    pc_unit_if bus();

    pc_unit #(.RESET_VECTOR(32'h0), .IMEM_BYTES(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input int id, input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step%0d %s got %h want %h", id, what, act, req);
        end
    endtask

    // monitor: one expected entry per negedge or explicit tick
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge mon_tick);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                cmp(e.id, "pc", bus.pc, e.pc);
                cmp(e.id, "pc_plus4", bus.pc_plus4, e.pc + 32'd4);
                cmp(e.id, "retired", bus.retired, e.ret);
                cmp(e.id, "fault", {31'd0, bus.fault}, {31'd0, e.flt});
                if (e.cfpc) cmp(e.id, "fault_pc", bus.fault_pc, e.fpc);
            end
        end
    end

    task automatic push(input logic [31:0] p, input logic [31:0] r, input logic f,
                        input logic [31:0] fp, input logic cf);
        exp_t e;
        e.pc = p; e.ret = r; e.flt = f; e.fpc = fp; e.cfpc = cf; e.id = next_id++;
        sb.push_back(e);
    endtask

    task automatic step(input logic st, input logic [1:0] sel, input logic a, input logic z,
                        input logic [15:0] im, input logic [25:0] ad, input logic [31:0] rt,
                        input logic [31:0] p, input logic [31:0] r, input logic f,
                        input logic [31:0] fp, input logic cf);
        bus.stall = st; bus.pc_sel = sel; bus.add_sel = a; bus.zero = z;
        bus.imm = im; bus.addr = ad; bus.reg_target = rt;
        @(posedge clk);
        #1 push(p, r, f, fp, cf);
    endtask

    // asserts reset between edges and checks before any clock edge arrives
    task automatic async_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1 push(32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        mon_tick = 1'b1;
        #1 mon_tick = 1'b0;
        #1 reset = 1'b0;
    endtask

    initial begin
        bus.stall = 0; bus.pc_sel = 0; bus.add_sel = 0; bus.zero = 0;
        bus.imm = 0; bus.addr = 0; bus.reg_target = 0;
        async_reset();
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h4,   1, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h8,   2, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'hC,   3, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h10,  4, 0, 0, 1);
        step(0, 2'b00, 1, 1, 16'hFFFE, 26'h0,   32'h0,   32'hC,   5, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h10,  6, 0, 0, 1);
        step(0, 2'b00, 1, 0, 16'hFFFE, 26'h0,   32'h0,   32'h14,  7, 0, 0, 1);
        step(0, 2'b10, 0, 0, 16'h0,    26'h0,   32'h20,  32'h20,  8, 0, 0, 1);
        step(0, 2'b01, 0, 0, 16'h0,    26'h40,  32'h0,   32'h100, 9, 0, 0, 1);
        step(0, 2'b10, 0, 0, 16'h0,    26'h0,   32'h3C,  32'h3C, 10, 0, 0, 1);
        step(0, 2'b10, 0, 0, 16'h0,    26'h0,   32'h8,   32'h8,  11, 0, 0, 1);
        step(1, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h8,  11, 0, 0, 1);
        step(1, 2'b11, 0, 0, 16'h0,    26'h0,   32'h102, 32'h8,  11, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h8,  11, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'hC,  12, 0, 0, 1);
        step(0, 2'b10, 0, 0, 16'h0,    26'h0,   32'h102, 32'hC,  12, 1, 32'h102, 1);
        step(0, 2'b10, 0, 0, 16'h0,    26'h0,   32'h40,  32'hC,  12, 1, 32'h102, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'hC,  12, 1, 32'h102, 1);
        step(1, 2'b01, 0, 0, 16'h0,    26'h4,   32'h0,   32'hC,  12, 1, 32'h102, 1);
        async_reset();
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h4,   1, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h8,   2, 0, 0, 1);
        step(0, 2'b01, 0, 0, 16'h0,    26'h100, 32'h0,   32'h8,   2, 1, 32'h400, 1);
        async_reset();
        step(0, 2'b10, 0, 0, 16'h0,    26'h0,   32'h3FC, 32'h3FC, 1, 0, 0, 1);
        step(0, 2'b00, 0, 0, 16'h0,    26'h0,   32'h0,   32'h3FC, 1, 1, 32'h400, 1);
        async_reset();
        step(0, 2'b11, 0, 0, 16'h0,    26'h0,   32'h8,   32'h0,   0, 1, 0, 0);
        async_reset();
        step(0, 2'b00, 1, 1, 16'hFFFE, 26'h0,   32'h0,   32'h0,   0, 1, 32'hFFFFFFFC, 1);
        async_reset();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
